// File: rtl/alu_pkg.sv
// Shared ALU dispatch definitions: ALU op codes, RV32I opcodes and the decoded entry type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_OR    = 4'b1100;
  localparam logic [3:0] ALU_AND   = 4'b1110;
  localparam logic [3:0] ALU_PASS2 = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;
  } alu_entry_t;

  // funct3 -> operation for the base (funct7 = 0) encodings shared by OP and OP-IMM
  function automatic logic [3:0] base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Upstream instruction/operand handshake and downstream ALU-operation handshake.
interface alu_dispatch_if;
  import alu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  rd;
  logic        rd_wen;
  logic        illegal;

  modport slave (
    input  in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_op, data1, data2, rd, rd_wen, illegal
  );

  modport master (
    output in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, data1, data2, rd, rd_wen, illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder producing one dispatch entry.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output alu_entry_t  entry_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        legal;
  logic [3:0]  op;
  logic [31:0] d1;
  logic [31:0] d2;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign shamt  = {27'b0, inst_i[24:20]};

  always_comb begin
    legal = 1'b0;
    op    = ALU_PASS2;
    d1    = '0;
    d2    = '0;
    case (opcode)
      OPC_OP: begin
        d1 = rs1_i;
        d2 = rs2_i;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          op    = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal = 1'b1;
          op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal = 1'b1;
          op    = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        d1 = rs1_i;
        d2 = imm_i;
        // Shift immediates carry only the shift amount; upper bits select SRL/SRA.
        if (funct3 == 3'b001) begin
          d2    = shamt;
          legal = (funct7 == F7_BASE);
          op    = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          d2    = shamt;
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          legal = 1'b1;
          op    = base_op(funct3);
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_PASS2;
        d2    = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op    = ALU_ADD;
        d1    = pc_i;
        d2    = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  assign entry_o.alu_op  = legal ? op : ALU_PASS2;
  assign entry_o.data1   = legal ? d1 : '0;
  assign entry_o.data2   = legal ? d2 : '0;
  assign entry_o.rd      = rd;
  assign entry_o.rd_wen  = legal && (rd != 5'd0);
  assign entry_o.illegal = !legal;

endmodule

// File: rtl/alu_dispatch.sv
// Decoded-instruction dispatch through a 2-entry skid FIFO to the ALU stage.
module alu_dispatch
  import alu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  alu_dispatch_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t       state_q, state_d;
  alu_entry_t head_q, head_d;
  alu_entry_t skid_q, skid_d;
  alu_entry_t dec_entry;
  logic       push;
  logic       pop;

  alu_decode u_decode (
    .inst_i  (bus.inst),
    .pc_i    (bus.pc),
    .rs1_i   (bus.rs1_data),
    .rs2_i   (bus.rs2_data),
    .entry_o (dec_entry)
  );

  // in_ready depends only on stored occupancy and flush, never on out_ready.
  assign bus.in_ready = (state_q != FULL) && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q != EMPTY) && bus.out_ready && !bus.flush;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_d  = dec_entry;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            head_d = dec_entry;
          end else if (push) begin
            skid_d  = dec_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.alu_op    = head_q.alu_op;
  assign bus.data1     = head_q.data1;
  assign bus.data2     = head_q.data2;
  assign bus.rd        = head_q.rd;
  assign bus.rd_wen    = head_q.rd_wen;
  assign bus.illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: random and directed instructions against a mnemonic-level model.
module tb_alu_dispatch;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   or_mode;   // 0 random out_ready, 1 always ready, 2 stalled
  exp_t sb[$];
  logic [3:0] code_of[string];

  alu_dispatch_if bus ();

  alu_dispatch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic string f3_name(input logic [2:0] f3);
    string names[8];
    names = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    return names[f3];
  endfunction

  // Reference: name the instruction, then derive operands and code from the name.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b);
    string       mn;
    logic [31:0] x;
    logic [31:0] y;
    logic [6:0]  f7;
    logic [2:0]  f3;
    exp_t        e;
    mn = "ILL";
    x  = 0;
    y  = 0;
    f7 = i[31:25];
    f3 = i[14:12];
    if (i[6:0] == 7'h33) begin
      x = a;
      y = b;
      if (f7 == 7'h00) mn = f3_name(f3);
      else if (f7 == 7'h20 && f3 == 3'd0) mn = "SUB";
      else if (f7 == 7'h20 && f3 == 3'd5) mn = "SRA";
    end else if (i[6:0] == 7'h13) begin
      x = a;
      y = $signed(i) >>> 20;
      if (f3 == 3'd1) begin
        y  = 32'(i[24:20]);
        mn = (f7 == 7'h00) ? "SLL" : "ILL";
      end else if (f3 == 3'd5) begin
        y  = 32'(i[24:20]);
        mn = (f7 == 7'h00) ? "SRL" : (f7 == 7'h20) ? "SRA" : "ILL";
      end else begin
        mn = f3_name(f3);
      end
    end else if (i[6:0] == 7'h37) begin
      mn = "PASS2";
      y  = i & 32'hFFFF_F000;
    end else if (i[6:0] == 7'h17) begin
      mn = "ADD";
      x  = pc;
      y  = i & 32'hFFFF_F000;
    end
    e.rd = i[11:7];
    if (mn == "ILL") begin
      e.op = 4'hF; e.d1 = 0; e.d2 = 0; e.wen = 1'b0; e.ill = 1'b1;
    end else begin
      e.op = code_of[mn]; e.d1 = x; e.d2 = y; e.wen = (i[11:7] != 0); e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [6:0] pick_f7();
    int s;
    s = $urandom_range(0, 4);
    if (s < 3) return 7'h00;
    if (s == 3) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3) begin
      r[6:0] = 7'h33; r[31:25] = pick_f7();
    end else if (k <= 6) begin
      r[6:0] = 7'h13;
      if (r[14:12] == 3'd1 || r[14:12] == 3'd5) r[31:25] = pick_f7();
    end else if (k == 7) r[6:0] = 7'h37;
    else if (k == 8) r[6:0] = 7'h17;
    return r;
  endfunction

  // One clock of stimulus; scoreboard push/flush bookkeeping happens before the edge.
  task automatic cycle_step(input logic iv, input logic [31:0] ins, input logic [31:0] pcv,
                            input logic [31:0] r1, input logic [31:0] r2, input logic fl,
                            input logic use_exp, input exp_t exp_in, output logic acc);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.inst      = ins;
    bus.pc        = pcv;
    bus.rs1_data  = r1;
    bus.rs2_data  = r2;
    bus.flush     = fl;
    bus.out_ready = (or_mode == 1) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    #2;
    acc = iv && bus.in_ready;
    if (fl) sb.delete();
    else if (acc) sb.push_back(use_exp ? exp_in : model(ins, pcv, r1, r2));
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] r1,
                      input logic [31:0] r2, input logic use_exp, input exp_t exp_in);
    logic acc;
    for (int n = 0; n < 64; n++) begin
      cycle_step(1'b1, ins, pcv, r1, r2, 1'b0, use_exp, exp_in, acc);
      if (acc) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: inst %h not accepted within 64 cycles", ins);
  endtask

  task automatic send_rand();
    send(rand_inst(), $urandom, $urandom, $urandom, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cycle_step(1'b0, $urandom, 0, 0, 0, 1'b0, 1'b0, '0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare the presented entry with the scoreboard head every cycle.
  initial begin
    exp_t got;
    forever begin
      @(negedge clk);
      #1;
      got = {bus.alu_op, bus.data1, bus.data2, bus.rd, bus.rd_wen, bus.illegal};
      if (rst) begin
        check("reset_outputs", 80'({bus.out_valid, got}), 80'(0));
      end else begin
        check("in_ready", 80'(bus.in_ready), 80'(sb.size() < 2 && !bus.flush));
        check("out_valid", 80'(bus.out_valid), 80'(sb.size() != 0));
        if (bus.out_valid && sb.size() != 0) begin
          check("entry", 80'(got), 80'(sb[0]));
          if (bus.out_ready && !bus.flush) begin
            $display("pop op=%b d1=%h d2=%h rd=%0d wen=%b ill=%b", got.op, got.d1, got.d2,
                     got.rd, got.wen, got.ill);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    n_cmp = 0;
    n_bad = 0;
    or_mode = 1;
    code_of["ADD"] = 4'b0000; code_of["SUB"] = 4'b0001; code_of["SLL"] = 4'b0010;
    code_of["SLT"] = 4'b0100; code_of["SLTU"] = 4'b0110; code_of["XOR"] = 4'b1000;
    code_of["SRL"] = 4'b1010; code_of["SRA"] = 4'b1011; code_of["OR"] = 4'b1100;
    code_of["AND"] = 4'b1110; code_of["PASS2"] = 4'b1111;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.inst = 0; bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations
    send(32'h4020_8033, 32'h100, 32'd5, 32'd7, 1'b1, exp_t'{4'b0001, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0});
    send(32'h4020_D093, 32'h104, 32'h8000_0000, 32'd0, 1'b1,
         exp_t'{4'b1011, 32'h8000_0000, 32'd2, 5'd1, 1'b1, 1'b0});
    send(32'h0000_1117, 32'h8000_0000, 32'd9, 32'd9, 1'b1,
         exp_t'{4'b0000, 32'h8000_0000, 32'h1000, 5'd2, 1'b1, 1'b0});
    send(32'h0200_0033, 32'h10c, 32'd3, 32'd4, 1'b1, exp_t'{4'b1111, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
    idle(3);

    // Back-pressure: third entry waits upstream until the ALU drains
    or_mode = 2;
    send_rand();
    send_rand();
    for (int k = 0; k < 3; k++) begin
      cycle_step(1'b1, 32'h0030_0193, 0, 0, 0, 1'b0, 1'b0, '0, acc);
      check("held_third", 80'(acc), 80'(0));
    end
    or_mode = 1;
    send(32'h0030_0193, 0, 0, 0, 1'b0, '0);
    idle(4);

    // Flush while full with a concurrent input
    or_mode = 2;
    send_rand();
    send_rand();
    cycle_step(1'b1, 32'h0050_0293, 0, 0, 0, 1'b1, 1'b0, '0, acc);
    check("flush_drops_input", 80'(acc), 80'(0));
    or_mode = 1;
    idle(2);

    // Reset mid-stream
    or_mode = 2;
    send_rand();
    send_rand();
    do_reset();
    idle(2);

    // Random traffic
    or_mode = 0;
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) cycle_step(1'($urandom_range(0, 1)), rand_inst(), 0, $urandom, $urandom, 1'b1,
                            1'b0, '0, acc);
      else if (r < 4) do_reset();
      else if (r < 20) idle(1);
      else send_rand();
      if (t % 100 == 50) or_mode = (or_mode == 0) ? 1 : 0;
    end

    or_mode = 1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    check("drained", 80'(sb.size()), 80'(0));
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
